button_debounce: RTL and testbench

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce_if.sv | 30 +++
 rtl/button_debounce.sv | 89 ++++++++
 tb/tb_button_debounce.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Button debouncer bus: raw buttons in; debounced levels, edge strobes and LED count out.
//   buttons       : raw asynchronous push-buttons, 1 = pressed
//   pressed       : debounced level per button
//   press_pulse   : one-cycle strobe on debounced 0->1
//   release_pulse : one-cycle strobe on debounced 1->0
//   led           : low nibble of the press counter
// The master drives buttons and observes the outputs; the slave is the debouncer.
interface button_debounce_if;
  logic [1:0] buttons;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [3:0] led;

  modport master (
    output buttons,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  led
  );

  modport slave (
    input  buttons,
    output pressed,
    output press_pulse,
    output release_pulse,
    output led
  );
endinterface

// File: rtl/button_debounce.sv
// Two-button debouncer with press/release strobes and a 6-bit press counter.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset (deassertion already synchronous to clk)
//   bus   : button_debounce_if.slave (buttons in; pressed, press_pulse,
//           release_pulse, led out)
// Button 0 presses increment the counter, button 1 presses clear it (clear wins).
module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  button_debounce_if.slave  bus
);

  // Counter wide enough for STABLE_CYCLES-1; 16 bits for the whole 2..65535 range.
  localparam int unsigned CNT_W   = ($clog2(STABLE_CYCLES) > 16) ? $clog2(STABLE_CYCLES) : 16;
  localparam int unsigned NBTN    = 2;
  localparam int unsigned PCNT_W  = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q [NBTN];
  logic [NBTN-1:0]        synced;
  logic [CNT_W-1:0]       cnt_q  [NBTN];
  logic [CNT_W-1:0]       cnt_d  [NBTN];
  logic [NBTN-1:0]        hit;
  logic [NBTN-1:0]        pressed_q;
  logic [NBTN-1:0]        press_pulse_q;
  logic [NBTN-1:0]        release_pulse_q;
  logic [PCNT_W-1:0]      press_cnt_q;

  // Metastability chain: raw buttons are only ever used as data into these flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NBTN); i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.buttons[i]};
    end
  end

  // Stability counters: restart whenever the synced level matches the debounced one.
  always_comb begin
    synced = '0;
    hit    = '0;
    for (int i = 0; i < int'(NBTN); i++) begin
      synced[i] = sync_q[i][SYNC_STAGES-1];
      cnt_d[i]  = '0;
      if (synced[i] != pressed_q[i]) begin
        if (cnt_q[i] == CNT_LAST) hit[i]   = 1'b1;
        else                      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level and strobes change on the same edge, so a strobe marks
  // the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= '0;
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
    end else begin
      for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= cnt_d[i];
      pressed_q       <= pressed_q ^ hit;
      press_pulse_q   <= hit & ~pressed_q;
      release_pulse_q <= hit & pressed_q;
    end
  end

  // Press counter: button 1 strobe clears, taking priority over a button 0 increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_cnt_q <= '0;
    end else if (press_pulse_q[1]) begin
      press_cnt_q <= '0;
    end else if (press_pulse_q[0]) begin
      press_cnt_q <= press_cnt_q + PCNT_W'(1);
    end
  end

  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = press_pulse_q;
  assign bus.release_pulse = release_pulse_q;
  assign bus.led           = press_cnt_q[3:0];

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (STABLE_CYCLES=4, SYNC_STAGES=2):
// directed latency/bounce/counter/reset sequences, a vector table, and a
// randomized run compared against a window-based reference model.
module tb_button_debounce;

  localparam int unsigned STABLE = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned HIST   = 8;

  logic clk;
  logic rst_n;

  button_debounce_if bus ();

  button_debounce #(
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a button toggles when the last STABLE synchronised samples
  // (raw samples delayed by SYNC edges) all differ from its debounced level.
  logic [1:0] hist [HIST];
  logic [1:0] m_pressed;
  logic [1:0] m_pp;
  logic [1:0] m_rp;
  logic [5:0] m_cnt;

  task automatic model_step();
    logic stable;
    if (!rst_n) begin
      for (int k = 0; k < int'(HIST); k++) hist[k] = 2'b00;
      m_pressed = 2'b00;
      m_pp      = 2'b00;
      m_rp      = 2'b00;
      m_cnt     = 6'd0;
    end else begin
      if (m_pp[1])      m_cnt = 6'd0;
      else if (m_pp[0]) m_cnt = m_cnt + 6'd1;
      for (int k = int'(HIST) - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = bus.buttons;
      m_pp = 2'b00;
      m_rp = 2'b00;
      for (int i = 0; i < 2; i++) begin
        stable = 1'b1;
        for (int k = int'(SYNC); k < int'(SYNC + STABLE); k++)
          if (hist[k][i] == m_pressed[i]) stable = 1'b0;
        if (stable) begin
          if (m_pressed[i]) m_rp[i] = 1'b1;
          else              m_pp[i] = 1'b1;
          m_pressed[i] = ~m_pressed[i];
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_release(input logic [1:0] b);
    bus.buttons = b;
    repeat (8) tick();
    bus.buttons = 2'b00;
    repeat (8) tick();
  endtask

  typedef struct {
    logic [1:0]  btn;
    int unsigned hold;
    logic [1:0]  exp_pressed;
    logic [3:0]  exp_led;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int cnt;
    int edge_at;
    int found;
    int hold;

    tbl[0]  = '{2'b00, 8, 2'b00, 4'd0};
    tbl[1]  = '{2'b01, 8, 2'b01, 4'd1};
    tbl[2]  = '{2'b00, 8, 2'b00, 4'd1};
    tbl[3]  = '{2'b01, 5, 2'b00, 4'd1};  // one edge short of the threshold
    tbl[4]  = '{2'b01, 1, 2'b01, 4'd1};  // level lands, count one edge later
    tbl[5]  = '{2'b01, 1, 2'b01, 4'd2};
    tbl[6]  = '{2'b11, 8, 2'b11, 4'd0};  // button 1 clears
    tbl[7]  = '{2'b10, 8, 2'b10, 4'd0};
    tbl[8]  = '{2'b00, 8, 2'b00, 4'd0};
    tbl[9]  = '{2'b01, 3, 2'b00, 4'd0};  // partial count ...
    tbl[10] = '{2'b00, 1, 2'b00, 4'd0};  // ... glitch back ...
    tbl[11] = '{2'b01, 5, 2'b00, 4'd0};  // ... restarts from zero
    tbl[12] = '{2'b01, 1, 2'b01, 4'd0};
    tbl[13] = '{2'b01, 1, 2'b01, 4'd1};
    tbl[14] = '{2'b00, 8, 2'b00, 4'd1};

    rst_n = 1'b0;
    bus.buttons = 2'b00;
    repeat (3) tick();
    chk("rst_pressed", 32'(bus.pressed), 32'd0);
    chk("rst_pp", 32'(bus.press_pulse), 32'd0);
    chk("rst_rp", 32'(bus.release_pulse), 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);

    // Button 0 held through reset release: lands on edge 6.
    bus.buttons = 2'b01;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("lat_e5_pressed", 32'(bus.pressed), 32'd0);
    end
    chk("lat_e6_pressed", 32'(bus.pressed), 32'd1);
    chk("lat_e6_pp", 32'(bus.press_pulse), 32'd1);
    tick();
    chk("lat_e7_pp", 32'(bus.press_pulse), 32'd0);
    chk("lat_e7_led", 32'(bus.led), 32'd1);

    // Release: one release strobe, 6 edges later, counter untouched.
    bus.buttons = 2'b00;
    cnt = 0; edge_at = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.release_pulse[0]) begin cnt++; edge_at = e; end
      if (bus.press_pulse != 2'b00) cnt += 100;
    end
    chk("rel_count", 32'(cnt), 32'd1);
    chk("rel_edge", 32'(edge_at), 32'd6);
    chk("rel_pressed", 32'(bus.pressed), 32'd0);
    chk("rel_led", 32'(bus.led), 32'd1);

    // Bounce 1,0,1,0 then hold: exactly one press, 6 edges after the held 1.
    cnt = 0; edge_at = 0;
    for (int b = 0; b < 4; b++) begin
      bus.buttons = (b % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      if (bus.press_pulse[0]) cnt++;
    end
    bus.buttons = 2'b01;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.press_pulse[0]) begin cnt++; edge_at = e; end
    end
    chk("bounce_count", 32'(cnt), 32'd1);
    chk("bounce_edge", 32'(edge_at), 32'd6);
    chk("bounce_led", 32'(bus.led), 32'd2);
    bus.buttons = 2'b00;
    repeat (8) tick();

    // 64 presses wrap the 6-bit counter back to zero.
    press_release(2'b10);
    chk("wrap_cleared", 32'(bus.led), 32'd0);
    for (int k = 1; k <= 64; k++) begin
      press_release(2'b01);
      chk($sformatf("wrap_led_%0d", k), 32'(bus.led), 32'(k % 16));
    end

    // Clear from 9.
    repeat (9) press_release(2'b01);
    chk("clr_pre", 32'(bus.led), 32'd9);
    bus.buttons = 2'b10;
    found = 0;
    for (int e = 0; e < 12 && found == 0; e++) begin
      tick();
      if (bus.press_pulse[1]) found = 1;
    end
    chk("clr_pulse_seen", 32'(found), 32'd1);
    chk("clr_led_at_pulse", 32'(bus.led), 32'd9);
    tick();
    chk("clr_led_after", 32'(bus.led), 32'd0);
    bus.buttons = 2'b00;
    repeat (8) tick();

    // Both buttons on the same edge: clear wins.
    repeat (3) press_release(2'b01);
    chk("both_pre", 32'(bus.led), 32'd3);
    bus.buttons = 2'b11;
    found = 0;
    for (int e = 0; e < 12 && found == 0; e++) begin
      tick();
      if (bus.press_pulse != 2'b00) found = 1;
    end
    chk("both_pulses", 32'(bus.press_pulse), 32'd3);
    tick();
    chk("both_led", 32'(bus.led), 32'd0);
    bus.buttons = 2'b00;
    repeat (8) tick();

    // Reset mid-debounce: immediate clear, then a full latency again.
    press_release(2'b01);
    chk("mid_pre_led", 32'(bus.led), 32'd1);
    bus.buttons = 2'b01;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(bus.led), 32'd0);
    chk("mid_rst_pressed", 32'(bus.pressed), 32'd0);
    chk("mid_rst_pulses", 32'({bus.press_pulse, bus.release_pulse}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    edge_at = 0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus.press_pulse[0] && edge_at == 0) edge_at = e;
    end
    chk("mid_rst_edge", 32'(edge_at), 32'd6);
    bus.buttons = 2'b00;
    repeat (8) tick();

    // Vector table from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int v = 0; v < 15; v++) begin
      bus.buttons = tbl[v].btn;
      repeat (tbl[v].hold) tick();
      chk($sformatf("tbl%0d_pressed", v), 32'(bus.pressed), 32'(tbl[v].exp_pressed));
      chk($sformatf("tbl%0d_led", v), 32'(bus.led), 32'(tbl[v].exp_led));
    end

    // Randomized bouncing against the reference model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        bus.buttons = 2'($urandom);
        hold = $urandom_range(1, 10);
      end
      hold--;
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
      chk("rnd_pressed", 32'(bus.pressed), 32'(m_pressed));
      chk("rnd_pp", 32'(bus.press_pulse), 32'(m_pp));
      chk("rnd_rp", 32'(bus.release_pulse), 32'(m_rp));
      chk("rnd_led", 32'(bus.led), 32'(m_cnt[3:0]));
      chk("rnd_excl", 32'(bus.press_pulse & bus.release_pulse), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
